// File: rtl/ss_request_sequencer.sv
// ss_request_sequencer: accepts savestate save/load pulses from the UI and
// hands them one at a time to the savestate engine. A one-deep pending
// buffer absorbs a request that arrives while busy. Completion, timeout and
// dropped-request events are reported as info pulses.
module ss_request_sequencer #(
    parameter logic [31:0] BASE_ADDR    = 32'h3C000000,
    parameter int          SLOT_SHIFT   = 23,
    parameter int          TIMEOUT_BITS = 26
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        allow_ss,
    input  logic        req_save,
    input  logic        req_load,
    input  logic [1:0]  req_slot,
    output logic        eng_start,
    output logic        eng_is_load,
    output logic [31:0] eng_addr,
    input  logic        eng_busy,
    input  logic        eng_done,
    output logic        info_req,
    output logic [7:0]  info,
    output logic        seq_busy,
    output logic        last_ok
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_REPORT} state_t;

    state_t                  r_state, w_next;
    logic                    r_pend_v, r_pend_op;
    logic [1:0]              r_pend_slot;
    logic                    r_op;
    logic [1:0]              r_slot;
    logic [31:0]             r_addr;
    logic [TIMEOUT_BITS-1:0] r_wd, w_wd_inc;
    logic                    r_ok, r_drop;

    logic                    w_valid_req, w_req_op, w_timeout, w_consume;
    logic                    w_cons_op, w_rep_ok;
    logic [1:0]              w_cons_slot;
    logic [31:0]             w_cons_addr;

    // Save wins over a simultaneous load, so op is load only without save.
    assign w_valid_req = allow_ss & (req_save | req_load);
    assign w_req_op    = ~req_save;
    assign w_wd_inc    = r_wd + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
    // Timeout is taken on the edge where the watchdog MSB becomes set.
    assign w_timeout   = w_wd_inc[TIMEOUT_BITS-1];
    // The pending buffer always has priority over a fresh request.
    assign w_consume   = (r_state == S_IDLE) & (r_pend_v | w_valid_req);
    assign w_cons_op   = r_pend_v ? r_pend_op   : w_req_op;
    assign w_cons_slot = r_pend_v ? r_pend_slot : req_slot;
    assign w_cons_addr = BASE_ADDR + ({30'b0, w_cons_slot} << SLOT_SHIFT);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; w_rep_ok carries the outcome into REPORT.
    always_comb begin
        w_next   = r_state;
        w_rep_ok = 1'b0;
        case (r_state)
            S_IDLE: if (w_consume) w_next = S_ISSUE;
            S_ISSUE: begin
                if (eng_busy && eng_done) begin
                    w_next   = S_REPORT;
                    w_rep_ok = 1'b1;
                end else if (eng_busy) begin
                    w_next = S_WAIT_DONE;
                end else if (w_timeout) begin
                    w_next = S_REPORT;
                end
            end
            S_WAIT_DONE: begin
                if (eng_done) begin
                    w_next   = S_REPORT;
                    w_rep_ok = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_REPORT;
                end
            end
            S_REPORT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath: current op, pending buffer, watchdog, result and drop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_v    <= 1'b0;
            r_pend_op   <= 1'b0;
            r_pend_slot <= 2'd0;
            r_op        <= 1'b0;
            r_slot      <= 2'd0;
            r_addr      <= 32'd0;
            r_wd        <= '0;
            r_ok        <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            if (w_consume) begin
                r_op   <= w_cons_op;
                r_slot <= w_cons_slot;
                r_addr <= w_cons_addr;
            end
            // A request arriving while pending is consumed refills the buffer.
            if (r_state == S_IDLE) begin
                if (r_pend_v) begin
                    r_pend_v <= w_valid_req;
                    if (w_valid_req) begin
                        r_pend_op   <= w_req_op;
                        r_pend_slot <= req_slot;
                    end
                end
            end else if (w_valid_req && !r_pend_v) begin
                r_pend_v    <= 1'b1;
                r_pend_op   <= w_req_op;
                r_pend_slot <= req_slot;
            end
            r_drop <= w_valid_req & (r_state != S_IDLE) & r_pend_v;
            case (r_state)
                S_ISSUE:     r_wd <= eng_busy ? '0 : w_wd_inc;
                S_WAIT_DONE: r_wd <= w_wd_inc;
                default:     r_wd <= '0;
            endcase
            if (r_state != S_REPORT && w_next == S_REPORT) r_ok <= w_rep_ok;
        end
    end

    // Outputs decode from state; the REPORT code overrides a colliding drop.
    always_comb begin
        eng_start   = (r_state == S_ISSUE);
        eng_is_load = r_op;
        eng_addr    = r_addr;
        seq_busy    = (r_state != S_IDLE);
        last_ok     = r_ok;
        info_req    = (r_state == S_REPORT) | r_drop;
        info        = 8'd0;
        if (r_state == S_REPORT) info = r_ok ? (8'd16 + {5'd0, r_slot, r_op}) : 8'd24;
        else if (r_drop)         info = 8'd25;
    end

endmodule

// File: tb/tb_ss_request_sequencer.sv
// Randomized bench for ss_request_sequencer. A transaction-level model turns
// each consumed request into a predicted report cycle and code from the
// engine response schedule the bench itself chooses; a monitor compares the
// DUT outputs against those predictions every cycle.
module tb_ss_request_sequencer;
    localparam int          TOB   = 4;
    localparam int          TO    = 1 << (TOB - 1);
    localparam logic [31:0] BASE  = 32'h3C000000;
    localparam int          SHIFT = 23;

    logic        clk, reset_n, allow_ss, req_save, req_load;
    logic [1:0]  req_slot;
    logic        eng_start, eng_is_load, eng_busy, eng_done;
    logic [31:0] eng_addr;
    logic        info_req, seq_busy, last_ok;
    logic [7:0]  info;

    ss_request_sequencer #(.BASE_ADDR(BASE), .SLOT_SHIFT(SHIFT), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .reset_n(reset_n), .allow_ss(allow_ss), .req_save(req_save),
        .req_load(req_load), .req_slot(req_slot), .eng_start(eng_start),
        .eng_is_load(eng_is_load), .eng_addr(eng_addr), .eng_busy(eng_busy),
        .eng_done(eng_done), .info_req(info_req), .info(info),
        .seq_busy(seq_busy), .last_ok(last_ok));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] code; bit ok; bit chk_ok; } ev_t;
    typedef struct { bit op; logic [1:0] slot; } req_t;

    ev_t  sb[$];
    req_t pq[$];
    int   vectors = 0, miscompares = 0;
    int   n = 0;
    bit   in_reset = 1'b1;

    // Current transaction: consumed at t_n0, engine busy at t_n0+t_bl, done
    // at t_n0+t_dl; eng_start is up through t_hi, report follows t_rep.
    bit          t_v = 1'b0, t_ok, t_op;
    int          t_n0, t_bl, t_dl, t_hi, t_rep;
    logic [31:0] t_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, n, act, exp);
        end
    endtask

    function automatic void push_ev(input int cyc, input logic [7:0] code, input bit ok, input bit chk);
        ev_t e;
        int  i = 0;
        e.cyc = cyc; e.code = code; e.ok = ok; e.chk_ok = chk;
        while (i < sb.size() && sb[i].cyc <= cyc) i++;
        sb.insert(i, e);
    endfunction

    task automatic start_txn(input int at, input bit op, input logic [1:0] slot);
        t_v = 1'b1; t_n0 = at; t_op = op;
        t_addr = BASE + 32'(slot) * (32'd1 << SHIFT);
        t_bl = $urandom_range(1, TO + 2);
        t_dl = t_bl + $urandom_range(0, TO + 2);
        if (t_bl > TO) begin
            t_hi = at + TO - 1; t_rep = at + TO; t_ok = 1'b0;
        end else begin
            t_hi = at + t_bl - 1;
            if (t_dl - t_bl <= TO) begin t_rep = at + t_dl;        t_ok = 1'b1; end
            else                   begin t_rep = at + t_bl + TO;  t_ok = 1'b0; end
        end
        push_ev(t_rep, t_ok ? 8'(16 + 2 * int'(slot) + int'(op)) : 8'd24, t_ok, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".eng_start"},   32'(eng_start),   32'd0);
        check({tag, ".eng_is_load"}, 32'(eng_is_load), 32'd0);
        check({tag, ".eng_addr"},    eng_addr,         32'd0);
        check({tag, ".info_req"},    32'(info_req),    32'd0);
        check({tag, ".info"},        32'(info),        32'd0);
        check({tag, ".seq_busy"},    32'(seq_busy),    32'd0);
        check({tag, ".last_ok"},     32'(last_ok),     32'd0);
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!in_reset) begin
                check("seq_busy",  32'(seq_busy),  32'(t_v && n >= t_n0 && n <= t_rep));
                check("eng_start", 32'(eng_start), 32'(t_v && n >= t_n0 && n <= t_hi));
                if (t_v && n >= t_n0 && n <= t_hi) begin
                    check("eng_addr",    eng_addr,         t_addr);
                    check("eng_is_load", 32'(eng_is_load), 32'(t_op));
                end
                while (sb.size() > 0 && sb[0].cyc < n) begin
                    e = sb.pop_front();
                    vectors++; miscompares++;
                    $display("FAIL missed_info at cycle %0d: got none, expected code %0d", e.cyc, e.code);
                end
                if (sb.size() > 0 && sb[0].cyc == n) begin
                    e = sb.pop_front();
                    check("info_req", 32'(info_req), 32'd1);
                    check("info",     32'(info),     32'(e.code));
                    if (e.chk_ok) check("last_ok", 32'(last_ok), 32'(e.ok));
                end else begin
                    check("info_req_idle", 32'(info_req), 32'd0);
                end
            end
        end
    end

    // Driver + reference model, one iteration per rising edge n.
    initial begin
        bit   did_reset = 1'b0;
        bit   v, op, s, l;
        logic [1:0] slot;
        req_t r;
        reset_n = 1'b0; allow_ss = 1'b0; req_save = 1'b0; req_load = 1'b0;
        req_slot = 2'd0; eng_busy = 1'b0; eng_done = 1'b0;
        #2;
        check_zero("reset");
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        in_reset = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            n++;
            // Asynchronous reset while the engine is working on a request.
            if (!did_reset && k >= 2000 && t_v && t_bl <= TO &&
                (n - 1) >= t_n0 + t_bl && (n - 1) < t_rep) begin
                did_reset = 1'b1;
                reset_n = 1'b0; in_reset = 1'b1;
                allow_ss = 1'b0; req_save = 1'b0; req_load = 1'b0;
                eng_busy = 1'b0; eng_done = 1'b0;
                #1;
                check_zero("async_reset");
                t_v = 1'b0; pq.delete(); sb.delete();
                @(negedge clk); n++;
                @(negedge clk); n++;
                reset_n = 1'b1; in_reset = 1'b0;
            end
            // Engine response follows the schedule chosen for this transaction.
            eng_busy = t_v && t_bl <= TO && n >= t_n0 + t_bl && n <= t_rep;
            eng_done = t_v && t_ok && n == t_rep;
            if ((!t_v || n >= t_rep + 1) && $urandom_range(0, 7) == 0) eng_done = 1'b1;
            allow_ss = ($urandom_range(0, 9) != 0);
            s        = ($urandom_range(0, 5) == 0);
            l        = ($urandom_range(0, 5) == 0);
            slot     = 2'($urandom_range(0, 3));
            req_save = s; req_load = l; req_slot = slot;
            v  = allow_ss && (s || l);
            op = !s && l;
            if (!t_v || n >= t_rep + 2) begin
                if (pq.size() > 0) begin
                    r = pq.pop_front();
                    start_txn(n, r.op, r.slot);
                    if (v) begin r.op = op; r.slot = slot; pq.push_back(r); end
                end else if (v) begin
                    start_txn(n, op, slot);
                end
            end else if (v) begin
                if (pq.size() == 0) begin
                    r.op = op; r.slot = slot; pq.push_back(r);
                end else if (n != t_rep) begin
                    push_ev(n, 8'd25, 1'b0, 1'b0);
                end
            end
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ss_request_sequencer.md
Name: ss_request_sequencer

Overview:
- Consumer end of the savestate UI request interface: accepts single-cycle save/load pulses with a 2-bit slot, and issues them one at a time to the savestate engine over a start/busy/done handshake.
- Holds a one-deep pending buffer and computes each slot's DDR base address.
- Reports completion, timeout and dropped requests through an info-code pulse interface with the same semantics as the UI's info port: request pulse plus 8-bit code.
- Sits between the savestate UI and the savestate engine in the top level.

Parameters:
- BASE_ADDR, 32'h3C000000, DDR byte address of slot 0.
- SLOT_SHIFT, 23, log2 of the slot stride in bytes; slot n starts at BASE_ADDR + (n << SLOT_SHIFT).
- TIMEOUT_BITS, 26, width of the watchdog counter; timeout fires when bit TIMEOUT_BITS-1 becomes set.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- allow_ss  in  1  new requests are accepted only while high
- req_save  in  1  one-cycle save request pulse
- req_load  in  1  one-cycle load request pulse
- req_slot  in  2  slot for the request, sampled in the same cycle as the pulse
- eng_start  out  1  request to engine; held high until eng_busy is seen
- eng_is_load  out  1  1 = load, 0 = save; valid while eng_start is high or eng_busy is high
- eng_addr  out  32  slot base address; valid with eng_is_load
- eng_busy  in  1  engine has accepted the request and is working
- eng_done  in  1  one-cycle completion pulse from the engine
- info_req  out  1  one-cycle info pulse
- info  out  8  info code; valid when info_req is high
- seq_busy  out  1  high in any state other than IDLE
- last_ok  out  1  1 = last operation completed, 0 = timed out; cleared on reset

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE, pending buffer is emptied, watchdog = 0. All outputs = 0 (eng_addr = 0, info = 0, last_ok = 0).
- Request capture: valid_req = allow_ss & (req_save | req_load).
  - If req_save and req_load are both high, save wins; the load is discarded silently.
  - Captured fields are op (1 = load) and slot.
- FSM states: IDLE, ISSUE, WAIT_DONE, REPORT.
- IDLE:
  - If the pending buffer is valid, it is consumed first and pending is cleared.
  - Otherwise a valid_req is consumed directly.
  - On consume: latch op and slot, set eng_is_load and eng_addr, go to ISSUE.
  - eng_start rises in the cycle after the request pulse (1-cycle latency).
- ISSUE:
  - eng_start = 1.
  - On eng_busy = 1: eng_start drops in the next cycle, watchdog clears, go to WAIT_DONE.
  - If eng_done arrives with eng_busy in the same cycle, go directly to REPORT with success.
- WAIT_DONE:
  - Watchdog increments every cycle.
  - eng_done = 1: success, go to REPORT.
  - Watchdog MSB set: timeout, go to REPORT.
  - The watchdog also runs in ISSUE; a timeout there drops eng_start the next cycle.
- REPORT (1 cycle):
  - info_req = 1.
  - On success: info = 8'd16 + {slot, op}, last_ok = 1.
  - On timeout: info = 8'd24, last_ok = 0.
  - Next state is IDLE.
- Pending buffer:
  - A valid_req arriving in any state other than IDLE-consume is stored if pending is empty.
  - If pending is full, the new request is dropped and info_req pulses with info = 8'd25 in the next cycle.
  - If that pulse collides with a REPORT pulse, the REPORT code wins and the drop is not reported.
- Address arithmetic: eng_addr = BASE_ADDR + ({30'b0, slot} << SLOT_SHIFT), modulo 2^32.
- eng_done while in IDLE or REPORT: ignored.
- allow_ss falling mid-operation: the current operation and a captured pending request still complete; only new captures are blocked.
- seq_busy = (state != IDLE).

Test Plan:
- req_save, slot 2, in IDLE:
  - eng_start = 1 in the next cycle with eng_is_load = 0 and eng_addr = 32'h3D000000.
  - eng_busy at cycle +3, eng_done at cycle +10 → one info_req with info = 8'd20 and last_ok = 1.
- req_save and req_load both high with slot 1: only the save is issued (eng_is_load = 0, eng_addr = 32'h3C800000); completion info = 8'd18.
- Load on slot 3 in flight, save on slot 0 arrives, then a load on slot 1 arrives:
  - The slot-0 save is queued and issued right after the slot-3 report (info 8'd23).
  - The slot-1 load is dropped with info = 8'd25.
- TIMEOUT_BITS = 4, engine never asserts eng_done:
  - Info 8'd24 arrives 8 cycles after entering WAIT_DONE; last_ok = 0; FSM returns to IDLE.
- allow_ss = 0 with req_load: no eng_start and no info; seq_busy stays 0.
- reset_n asserted low during WAIT_DONE: outputs are 0 immediately (asynchronously); after release, a req_load on slot 0 is issued normally.
